// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down event counter: default width and
// direction encodings.
package up_down_counter_pkg;

  localparam int UDC_WIDTH = 8;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// Programmable-modulus up/down counter with a wrap pulse, a wrap counter
// and a zero indicator. One wrap every in+1 clocks in either direction.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             flag,
  output logic [WIDTH-1:0] flag_count,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_flag;
  logic [WIDTH-1:0] r_flag_count;

  logic             w_wrap;
  logic [WIDTH-1:0] w_next;

  // Up mode wraps on >= so that lowering `in` below the current count
  // recovers on the very next edge instead of running through 2^WIDTH.
  always_comb begin
    w_wrap = 1'b0;
    w_next = r_count;
    if (mode == MODE_UP) begin
      w_wrap = (r_count >= in);
      w_next = w_wrap ? '0 : r_count + ONE;
    end else begin
      w_wrap = (r_count == '0);
      w_next = w_wrap ? in : r_count - ONE;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_count      <= '0;
      r_flag       <= 1'b0;
      r_flag_count <= '0;
    end else begin
      r_count <= w_next;
      r_flag  <= w_wrap;
      if (w_wrap) begin
        r_flag_count <= r_flag_count + ONE;
      end
    end
  end

  assign count      = r_count;
  assign flag       = r_flag;
  assign flag_count = r_flag_count;
  assign zero       = (r_count == '0);

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter; each check compares the
// packed tuple {count, flag, flag_count, zero} against hand-computed values.
module tb_up_down_counter;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] in;
  logic [7:0] count;
  logic       flag;
  logic [7:0] flag_count;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;

  up_down_counter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in         (in),
    .count      (count),
    .flag       (flag),
    .flag_count (flag_count),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step(1);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mode = 1'b0; in = 8'd60;
    step(2);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got cnt=%0d flg=%b fc=%0d z=%b want 0 0 0 1", count, flag, flag_count, zero);
    end
    rst_n = 1'b0;
    step(3);
    // Pulse between edges must not reset anything.
    #2 rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd4, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_pulse: got cnt=%0d flg=%b fc=%0d z=%b want 4 0 0 0", count, flag, flag_count, zero);
    end
    do_reset();
  endtask

  task automatic test_up_wrap();
    mode = 1'b0; in = 8'd60;
    step(60);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd60, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL up_at_60: got cnt=%0d flg=%b fc=%0d z=%b want 60 0 0 0", count, flag, flag_count, zero);
    end
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd0, 1'b1, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL up_wrap1: got cnt=%0d flg=%b fc=%0d z=%b want 0 1 1 1", count, flag, flag_count, zero);
    end
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd1, 1'b0, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL up_flag_drop: got cnt=%0d flg=%b fc=%0d z=%b want 1 0 1 0", count, flag, flag_count, zero);
    end
    step(60);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd0, 1'b1, 8'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL up_wrap2: got cnt=%0d flg=%b fc=%0d z=%b want 0 1 2 1", count, flag, flag_count, zero);
    end
  endtask

  task automatic test_down_reload();
    mode = 1'b1;
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd60, 1'b1, 8'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL down_reload1: got cnt=%0d flg=%b fc=%0d z=%b want 60 1 3 0", count, flag, flag_count, zero);
    end
    step(60);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd0, 1'b0, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL down_at_0: got cnt=%0d flg=%b fc=%0d z=%b want 0 0 3 1", count, flag, flag_count, zero);
    end
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd60, 1'b1, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL down_reload2: got cnt=%0d flg=%b fc=%0d z=%b want 60 1 4 0", count, flag, flag_count, zero);
    end
  endtask

  task automatic test_direction_change();
    // count=60, in=60: switching to up wraps immediately.
    mode = 1'b0;
    step(1);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd0, 1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL dir_up_wrap: got cnt=%0d flg=%b fc=%0d want 0 1 5", count, flag, flag_count);
    end
    step(25);
    mode = 1'b1;
    for (int k = 24; k >= 20; k--) begin
      step(1);
      n_tests++;
      if ({count, flag, flag_count} !== {8'(k), 1'b0, 8'd5}) begin
        n_fail++;
        $display("FAIL dir_down: got cnt=%0d flg=%b fc=%0d want %0d 0 5", count, flag, flag_count, k);
      end
    end
    mode = 1'b0;
    step(1);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd21, 1'b0, 8'd5}) begin
      n_fail++;
      $display("FAIL dir_back_up: got cnt=%0d flg=%b fc=%0d want 21 0 5", count, flag, flag_count);
    end
  endtask

  task automatic test_in_lowered();
    step(29);
    n_tests++;
    if (count !== 8'd50) begin
      n_fail++;
      $display("FAIL lower_pre: got cnt=%0d want 50", count);
    end
    in = 8'd10;
    step(1);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd0, 1'b1, 8'd6}) begin
      n_fail++;
      $display("FAIL lower_wrap: got cnt=%0d flg=%b fc=%0d want 0 1 6", count, flag, flag_count);
    end
    // Down mode above `in` keeps decrementing without clamping.
    in = 8'd60; step(50);
    in = 8'd10; mode = 1'b1;
    step(1);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd49, 1'b0, 8'd6}) begin
      n_fail++;
      $display("FAIL down_no_clamp: got cnt=%0d flg=%b fc=%0d want 49 0 6", count, flag, flag_count);
    end
  endtask

  task automatic test_in_zero();
    do_reset();
    in = 8'd0; mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_tests++;
      if ({count, flag, flag_count, zero} !== {8'd0, 1'b1, 8'(k), 1'b1}) begin
        n_fail++;
        $display("FAIL in0_up: got cnt=%0d flg=%b fc=%0d z=%b want 0 1 %0d 1", count, flag, flag_count, zero, k);
      end
    end
    mode = 1'b1;
    step(2);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd0, 1'b1, 8'd6}) begin
      n_fail++;
      $display("FAIL in0_down: got cnt=%0d flg=%b fc=%0d want 0 1 6", count, flag, flag_count);
    end
  endtask

  task automatic test_flag_count_wrap();
    do_reset();
    in = 8'd0; mode = 1'b0;
    step(255);
    n_tests++;
    if (flag_count !== 8'd255) begin
      n_fail++;
      $display("FAIL fc_255: got fc=%0d want 255", flag_count);
    end
    step(1);
    n_tests++;
    if ({flag_count, flag} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fc_rollover: got fc=%0d flg=%b want 0 1", flag_count, flag);
    end
  endtask

  task automatic test_full_range();
    do_reset();
    in = 8'd255; mode = 1'b0;
    step(255);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd255, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL full_255: got cnt=%0d flg=%b fc=%0d want 255 0 0", count, flag, flag_count);
    end
    step(1);
    n_tests++;
    if ({count, flag, flag_count} !== {8'd0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL full_wrap: got cnt=%0d flg=%b fc=%0d want 0 1 1", count, flag, flag_count);
    end
  endtask

  task automatic test_reset_on_wrap();
    do_reset();
    in = 8'd3; mode = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    n_tests++;
    if ({count, flag, flag_count, zero} !== {8'd0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_on_wrap: got cnt=%0d flg=%b fc=%0d z=%b want 0 0 0 1", count, flag, flag_count, zero);
    end
    rst_n = 1'b0;
    step(1);
    n_tests++;
    if ({count, flag} !== {8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_on_wrap: got cnt=%0d flg=%b want 1 0", count, flag);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_reload();
    test_direction_change();
    test_in_lowered();
    test_in_zero();
    test_flag_count_wrap();
    test_full_range();
    test_reset_on_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
